// File: rtl/hazard_unit_if.sv
// Hazard-unit port bundle: datapath-side hazard inputs and pipeline control outputs.
// The datapath uses the master modport and hazard_unit uses the slave modport.
interface hazard_unit_if #(
    parameter int RF_ADDR_WIDTH = 5
);
    logic [RF_ADDR_WIDTH-1:0] i_RsD;
    logic [RF_ADDR_WIDTH-1:0] i_RtD;
    logic [RF_ADDR_WIDTH-1:0] i_RsE;
    logic [RF_ADDR_WIDTH-1:0] i_RtE;
    logic [RF_ADDR_WIDTH-1:0] i_WriteRegE;
    logic [RF_ADDR_WIDTH-1:0] i_WriteRegM;
    logic [RF_ADDR_WIDTH-1:0] i_WriteRegW;
    logic                     i_RegWriteE;
    logic                     i_RegWriteM;
    logic                     i_RegWriteW;
    logic                     i_MemtoRegE;
    logic                     i_MemtoRegM;
    logic                     i_BranchD;
    logic                     i_JumpRegD;
    logic                     i_MulDivStartE;
    logic                     i_MulDivIsDivE;
    logic [1:0]               o_ForwardAE;
    logic [1:0]               o_ForwardBE;
    logic                     o_ForwardAD;
    logic                     o_ForwardBD;
    logic                     o_StallF;
    logic                     o_StallD;
    logic                     o_StallE;
    logic                     o_FlushE;
    logic                     o_MulDivBusy;
    logic                     o_MulDivDone;
    // Debug view of the mul/div FSM: 0 IDLE, 1 BUSY, 2 DONE.
    logic [1:0]               o_DbgState;

    // There is no valid/ready handshake: every signal is a level, sampled each cycle.
    modport master (
        output i_RsD, i_RtD, i_RsE, i_RtE, i_WriteRegE, i_WriteRegM, i_WriteRegW,
               i_RegWriteE, i_RegWriteM, i_RegWriteW, i_MemtoRegE, i_MemtoRegM,
               i_BranchD, i_JumpRegD, i_MulDivStartE, i_MulDivIsDivE,
        input  o_ForwardAE, o_ForwardBE, o_ForwardAD, o_ForwardBD, o_StallF, o_StallD,
               o_StallE, o_FlushE, o_MulDivBusy, o_MulDivDone, o_DbgState
    );

    modport slave (
        input  i_RsD, i_RtD, i_RsE, i_RtE, i_WriteRegE, i_WriteRegM, i_WriteRegW,
               i_RegWriteE, i_RegWriteM, i_RegWriteW, i_MemtoRegE, i_MemtoRegM,
               i_BranchD, i_JumpRegD, i_MulDivStartE, i_MulDivIsDivE,
        output o_ForwardAE, o_ForwardBE, o_ForwardAD, o_ForwardBD, o_StallF, o_StallD,
               o_StallE, o_FlushE, o_MulDivBusy, o_MulDivDone, o_DbgState
    );
endinterface

// File: rtl/hazard_unit.sv
// Five-stage MIPS hazard controller: forwarding selects, load-use/branch stalls, and mul/div occupancy.
// The mul/div FSM is compiled in only when HAZARD_MULDIV_EN is defined.
module hazard_unit #(
    parameter int RF_ADDR_WIDTH = 5,
    parameter int MUL_CYCLES    = 4,
    parameter int DIV_CYCLES    = 32,
    parameter int CNT_WIDTH     = 6
) (
    input logic          i_CLK,
    input logic          i_RST,
    hazard_unit_if.slave hz
);
    localparam logic [RF_ADDR_WIDTH-1:0] ZERO_REG = '0;

    logic lwstall;
    logic brstall;
    logic mdstall;
    logic m_fwd_ok;
    logic w_fwd_ok;

    // A destination is only a forwarding source when it writes and is not $zero.
    assign m_fwd_ok = hz.i_RegWriteM && (hz.i_WriteRegM != ZERO_REG);
    assign w_fwd_ok = hz.i_RegWriteW && (hz.i_WriteRegW != ZERO_REG);

    always_comb begin
        hz.o_ForwardAE = 2'b00;
        hz.o_ForwardBE = 2'b00;
        if (m_fwd_ok && (hz.i_WriteRegM == hz.i_RsE)) begin
            hz.o_ForwardAE = 2'b10;
        end else if (w_fwd_ok && (hz.i_WriteRegW == hz.i_RsE)) begin
            hz.o_ForwardAE = 2'b01;
        end
        if (m_fwd_ok && (hz.i_WriteRegM == hz.i_RtE)) begin
            hz.o_ForwardBE = 2'b10;
        end else if (w_fwd_ok && (hz.i_WriteRegW == hz.i_RtE)) begin
            hz.o_ForwardBE = 2'b01;
        end
    end

    assign hz.o_ForwardAD = (hz.i_RsD != ZERO_REG) && (hz.i_RsD == hz.i_WriteRegM) && hz.i_RegWriteM;
    assign hz.o_ForwardBD = (hz.i_RtD != ZERO_REG) && (hz.i_RtD == hz.i_WriteRegM) && hz.i_RegWriteM;

    assign lwstall = hz.i_MemtoRegE && (hz.i_WriteRegE != ZERO_REG) &&
                     ((hz.i_WriteRegE == hz.i_RsD) || (hz.i_WriteRegE == hz.i_RtD));

    // Early branch compare cannot see an ALU result still in E, nor load data still in M.
    assign brstall = (hz.i_BranchD || hz.i_JumpRegD) && (
                     (hz.i_RegWriteE && (hz.i_WriteRegE != ZERO_REG) &&
                      ((hz.i_WriteRegE == hz.i_RsD) || (hz.i_WriteRegE == hz.i_RtD))) ||
                     (hz.i_MemtoRegM && (hz.i_WriteRegM != ZERO_REG) &&
                      ((hz.i_WriteRegM == hz.i_RsD) || (hz.i_WriteRegM == hz.i_RtD))));

`ifdef HAZARD_MULDIV_EN
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } md_state_t;

    md_state_t            state;
    md_state_t            state_next;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] cnt_next;

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (hz.i_MulDivStartE) begin
                    state_next = BUSY;
                    cnt_next   = hz.i_MulDivIsDivE ? CNT_WIDTH'(DIV_CYCLES - 1)
                                                   : CNT_WIDTH'(MUL_CYCLES - 1);
                end
            end
            BUSY: begin
                if (cnt == '0) begin
                    state_next = DONE;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // DONE releases the stall so the finished instruction leaves E at the end of that cycle.
    assign mdstall         = ((state == IDLE) && hz.i_MulDivStartE) || (state == BUSY);
    assign hz.o_MulDivBusy = (state != IDLE);
    assign hz.o_MulDivDone = (state == DONE);
    assign hz.o_StallE     = mdstall;
    assign hz.o_DbgState   = state;
`else
    logic unused_md;
    assign unused_md = ^{i_CLK, i_RST, hz.i_MulDivStartE, hz.i_MulDivIsDivE,
                         MUL_CYCLES, DIV_CYCLES, CNT_WIDTH};

    assign mdstall         = 1'b0;
    assign hz.o_MulDivBusy = 1'b0;
    assign hz.o_MulDivDone = 1'b0;
    assign hz.o_StallE     = 1'b0;
    assign hz.o_DbgState   = 2'd0;
`endif

    assign hz.o_StallF = lwstall | brstall | mdstall;
    assign hz.o_StallD = lwstall | brstall | mdstall;
    // An instruction held in E by a mul/div must never be replaced by a bubble.
    assign hz.o_FlushE = (lwstall | brstall) & ~mdstall;
endmodule
